// File: rtl/pix_serializer.sv
// pix_serializer: streams DATA_W-bit pixel words out LANES bits per beat.
// A one-word hold register lets the next word queue behind the word that is
// currently shifting, so consecutive words leave with no idle beat.
//
// Ports:
//   sclk         clock, rising edge
//   rst          asynchronous active-high reset
//   pix_in       pixel word, captured when in_valid && in_ready
//   in_valid     pix_in is valid
//   in_ready     a word can be accepted this cycle (hold register empty)
//   shift_en     consume the beat currently on ser_out
//   ser_out      current beat (LANES bits)
//   ser_valid    ser_out holds a valid beat
//   frame_first  current beat is beat 0 of its word
//   frame_last   current beat is the final beat of its word
//   underrun     sticky: shift_en seen while no beat was valid
//   clr_err      synchronous clear of underrun
module pix_serializer #(
  parameter int unsigned DATA_W    = 42,
  parameter int unsigned LANES     = 2,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              shift_en,
  output logic [LANES-1:0]  ser_out,
  output logic              ser_valid,
  output logic              frame_first,
  output logic              frame_last,
  output logic              underrun,
  input  logic              clr_err
);

  localparam int unsigned BEATS = DATA_W / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((LANES == 0) || ((DATA_W % LANES) != 0)) begin : g_bad_params
    $error("pix_serializer: DATA_W must be a non-zero multiple of LANES");
  end

  // IDLE: shift register empty; SHIFT: shift register holds a word
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] hr;
  logic              hr_full;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              consume;
  logic              last;
  logic              sr_empties;
  logic [DATA_W-1:0] sr_shifted;

  assign accept     = in_valid && !hr_full;
  assign consume    = shift_en && (state == SHIFT);
  assign last       = consume && (cnt == LAST_BEAT);
  assign sr_empties = (state == IDLE) || last;

  // Lane order selects which end of sr is on the wire and which way it moves
  if (MSB_FIRST != 0) begin : g_msb
    assign sr_shifted = sr << LANES;
    assign ser_out    = sr[DATA_W-1 -: LANES];
  end else begin : g_lsb
    assign sr_shifted = sr >> LANES;
    assign ser_out    = sr[LANES-1:0];
  end

  assign in_ready    = !hr_full;
  assign ser_valid   = (state == SHIFT);
  assign frame_first = (state == SHIFT) && (cnt == '0);
  assign frame_last  = (state == SHIFT) && (cnt == LAST_BEAT);

  // Word storage, beat counter and state
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      hr      <= '0;
      hr_full <= 1'b0;
      cnt     <= '0;
    end else if (sr_empties) begin
      // hr can only be full while a word is shifting, so accept and a
      // pending hr word never coincide here
      if (hr_full) begin
        sr      <= hr;
        hr_full <= 1'b0;
        cnt     <= '0;
        state   <= SHIFT;
      end else if (accept) begin
        sr    <= pix_in;
        cnt   <= '0;
        state <= SHIFT;
      end else begin
        sr    <= '0;
        cnt   <= '0;
        state <= IDLE;
      end
    end else begin
      if (accept) begin
        hr      <= pix_in;
        hr_full <= 1'b1;
      end
      if (consume) begin
        sr  <= sr_shifted;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Sticky underrun; a new underrun beats a simultaneous clear
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (shift_en && (state == IDLE)) begin
      underrun <= 1'b1;
    end else if (clr_err) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: doc/pix_serializer.md
# pix_serializer

Parametrised pixel-word serializer for the readout path: accepts `DATA_W`-bit pixel words over a valid/ready handshake and emits them `LANES` bits per beat under an external shift strobe. A one-word holding buffer lets the next word be accepted while the current one is shifting, so back-to-back words stream with no idle beat. It replaces the fixed 42-bit/2-lane shift register in the serial-out path and adds a beat counter, frame markers, bit-order selection and underrun detection.

## Interface
- `DATA_W`, 42, pixel word width; must be a multiple of `LANES`
- `LANES`, 2, serial lanes (bits per beat), ≥1
- `MSB_FIRST`, 0, 0: least-significant lane group first; 1: most-significant first
- BEATS = DATA_W/LANES (21 at defaults); CNT_W = max(1, $clog2(BEATS))

Ports:
- `sclk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pix_in`  in  DATA_W  pixel word
- `in_valid`  in  1  pix_in valid
- `in_ready`  out  1  block can accept a word this cycle
- `shift_en`  in  1  consume current beat
- `ser_out`  out  LANES  current beat data
- `ser_valid`  out  1  ser_out holds a valid beat
- `frame_first`  out  1  current beat is beat 0 of a word
- `frame_last`  out  1  current beat is beat BEATS-1
- `underrun`  out  1  sticky: shift_en seen while ser_valid low
- `clr_err`  in  1  synchronous clear of underrun

## Operation
- Storage: shift register `sr` (DATA_W), `sr_full`; hold register `hr` (DATA_W), `hr_full`; beat counter `cnt` (CNT_W).
- States: IDLE (`sr_full`=0) and SHIFT (`sr_full`=1). ser_valid = sr_full.
- in_ready = !hr_full (combinational from a register only; no dependence on in_valid/shift_en).
- Accept = in_valid && in_ready. Consume = shift_en && sr_full. Last = Consume && cnt==BEATS-1.
- sr empties at this edge if IDLE, or Last.
- On sr emptying: if hr_full, hr→sr, hr_full←0 (unless new word accepted, then it goes to hr); else if Accept, pix_in→sr directly (bypass); else sr_full←0. cnt←0 on any load.
- sr not emptying: Accept writes hr, hr_full←1.
- Consume, not Last: sr shifts by LANES (toward LSB if MSB_FIRST=0, toward MSB otherwise, zero fill), cnt+1.
- ser_out = sr[LANES-1:0] (MSB_FIRST=0) or sr[DATA_W-1 -: LANES] (MSB_FIRST=1).
- frame_first = sr_full && cnt==0; frame_last = sr_full && cnt==BEATS-1. BEATS=1 asserts both.
- shift_en with sr_full=0 ignored for data; sets underrun. clr_err clears it; a simultaneous new underrun wins (stays 1).
- Reset (async assert, any state, mid-word included): sr, hr, cnt ← 0; sr_full, hr_full, underrun ← 0. Thus in_ready=1, ser_valid=0, ser_out=0, frame_first=frame_last=0. Partially shifted word is discarded.

## Timing
- Accept in IDLE at edge N → ser_valid=1, beat 0 on ser_out from N (visible cycle N+1).
- Word occupies exactly BEATS consuming cycles; with shift_en held high and hr_full, next word's beat 0 follows beat BEATS-1 with zero gap.
- Max occupancy two words; in_ready low from edge hr fills until edge hr transfers to sr.
- Simultaneous Last + Accept with hr empty: bypass into sr, no gap, in_ready stays 1.
- Simultaneous Last + Accept with hr full: not possible (in_ready=0).
- Throughput: one word per BEATS cycles sustained.

## Test plan
- Reset/idle: assert rst mid-shift of word 0x2AA_AAAA_AAAA → next cycle ser_valid=0, ser_out=0, in_ready=1, underrun=0.
- Single word, defaults: accept 0x3_0000_0000_01, shift_en high → 21 beats, ser_out=2'b01 at beat 0, 0 at beats 1–19, 2'b11 at beat 20; frame_first at beat 0, frame_last at beat 20, then ser_valid=0.
- Back-to-back: three words offered continuously, shift_en held high → 63 contiguous valid beats, in_ready low while hr full, no bubble between words.
- Stalled shift: shift_en toggled 1/0 → ser_out/cnt hold during low cycles; word completes after 21 consumes.
- MSB_FIRST=1, DATA_W=8, LANES=4: word 0xA5 → beats 4'hA, 4'h5.
- Underrun: shift_en in IDLE → underrun=1 next cycle, stays until clr_err; clr_err with concurrent shift_en in IDLE keeps underrun=1.
